// File: rtl/game_music_player.sv
// Background-music sequencer: picks a ROM track from oxygen and win/loss
// status, steps ROM addresses per sample tick and feeds the audio codec.
//
// Ports:
//   CLOCK_50, resetn            clock, synchronous active-low reset
//   oxy_hi, oxy_lo              oxygen countdown as two BCD digits
//   game_win, game_loss         win pulse (latched), loss level
//   mute, vol_shift             force silence, left-shift volume
//   audio_out_allowed           codec ready, mirrored to write_audio_out
//   q_full/q_low/q_danger/q_win ROM samples, one cycle after the address
//   long_addr, short_addr       ROM addresses (full+win, low+danger)
//   audio_left, audio_right     scaled sample held between captures
//   write_audio_out             codec write strobe
//   sample_tick                 one-cycle pulse per sample period
//   track_state                 current state code
module game_music_player #(
    parameter int CLK_DIV       = 6250,
    parameter int ADDR_W        = 16,
    parameter int SAMPLE_W      = 8,
    parameter int OUT_W         = 32,
    parameter int LONG_LEN      = 64000,
    parameter int SHORT_LEN     = 32000,
    parameter int LOW_THRESH    = 12,
    parameter int DANGER_THRESH = 8,
    parameter int WIN_LOOP      = 0
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [3:0]          oxy_hi,
    input  logic [3:0]          oxy_lo,
    input  logic                game_win,
    input  logic                game_loss,
    input  logic                mute,
    input  logic [2:0]          vol_shift,
    input  logic                audio_out_allowed,
    input  logic [SAMPLE_W-1:0] q_full,
    input  logic [SAMPLE_W-1:0] q_low,
    input  logic [SAMPLE_W-1:0] q_danger,
    input  logic [SAMPLE_W-1:0] q_win,
    output logic [ADDR_W-1:0]   long_addr,
    output logic [ADDR_W-1:0]   short_addr,
    output logic [OUT_W-1:0]    audio_left,
    output logic [OUT_W-1:0]    audio_right,
    output logic                write_audio_out,
    output logic                sample_tick,
    output logic [2:0]          track_state
);

    typedef enum logic [2:0] {
        SILENT = 3'd0,
        FULL   = 3'd1,
        LOW    = 3'd2,
        DANGER = 3'd3,
        WIN    = 3'd4,
        LOSS   = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0]  DIV_MAX   = CNT_W'(CLK_DIV - 1);
    localparam logic [ADDR_W-1:0] LONG_MAX  = ADDR_W'(LONG_LEN - 1);
    localparam logic [ADDR_W-1:0] SHORT_MAX = ADDR_W'(SHORT_LEN - 1);
    localparam logic [7:0]        LOW_T     = 8'(LOW_THRESH);
    localparam logic [7:0]        DANGER_T  = 8'(DANGER_THRESH);

    logic [CNT_W-1:0]    div_cnt;
    logic [7:0]          ox;
    logic                win_lock;
    state_t              state;
    state_t              state_nxt;
    state_t              target;
    state_t              st_d1;
    logic [ADDR_W-1:0]   long_nxt;
    logic [ADDR_W-1:0]   short_nxt;
    logic                tick_d1;
    logic                tick_d2;
    logic [SAMPLE_W-1:0] sel;
    logic [OUT_W-1:0]    scaled;
    logic [OUT_W-1:0]    audio_q;

    assign sample_tick     = (div_cnt == DIV_MAX);
    assign ox              = {4'd0, oxy_hi} * 8'd10 + {4'd0, oxy_lo};
    assign track_state     = state;
    assign write_audio_out = audio_out_allowed;
    assign audio_left      = audio_q;
    assign audio_right     = audio_q;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            div_cnt <= '0;
        end else if (sample_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Sticky so a one-cycle win pulse still selects the win track.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            win_lock <= 1'b0;
        end else if (game_win) begin
            win_lock <= 1'b1;
        end
    end

    always_comb begin
        target = FULL;
        if (win_lock) begin
            target = WIN;
        end else if (game_loss) begin
            target = LOSS;
        end else if (ox < DANGER_T) begin
            target = DANGER;
        end else if (ox < LOW_T) begin
            target = LOW;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state      <= SILENT;
            long_addr  <= '0;
            short_addr <= '0;
        end else begin
            state      <= state_nxt;
            long_addr  <= long_nxt;
            short_addr <= short_nxt;
        end
    end

    // A track change restarts both ROMs; DONE ignores the target.
    always_comb begin
        state_nxt = state;
        long_nxt  = long_addr;
        short_nxt = short_addr;
        if (sample_tick && state != DONE) begin
            if (target != state) begin
                state_nxt = target;
                long_nxt  = '0;
                short_nxt = '0;
            end else if (state inside {FULL, LOW, DANGER, WIN}) begin
                if (state == WIN && WIN_LOOP == 0
                    && long_addr == LONG_MAX) begin
                    state_nxt = DONE;
                    long_nxt  = '0;
                    short_nxt = '0;
                end else begin
                    long_nxt  = (long_addr == LONG_MAX)
                                ? '0 : long_addr + 1'b1;
                    short_nxt = (short_addr == SHORT_MAX)
                                ? '0 : short_addr + 1'b1;
                end
            end
        end
    end

    // Tick delayed twice: ROM data for the new address is valid one
    // cycle after the tick edge and is captured on the following edge.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            tick_d1 <= 1'b0;
            tick_d2 <= 1'b0;
            st_d1   <= SILENT;
        end else begin
            tick_d1 <= sample_tick;
            tick_d2 <= tick_d1;
            st_d1   <= state;
        end
    end

    always_comb begin
        sel = '0;
        case (st_d1)
            FULL:    sel = q_full;
            LOW:     sel = q_low;
            DANGER:  sel = q_danger;
            WIN:     sel = q_win;
            default: sel = '0;
        endcase
    end

    assign scaled = OUT_W'(sel) << vol_shift;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            audio_q <= '0;
        end else if (tick_d2) begin
            audio_q <= mute ? '0 : scaled;
        end
    end

endmodule
